i2s_rx_frame_packer: RTL

I2S_RX_FRAME_PACKER -- requirements
Module: i2s_rx_frame_packer

---
 rtl/i2s_rx_frame_packer.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/i2s_rx_frame_packer.sv
// ---------------------------------------------------------------------------
// i2s_rx_frame_packer
//
// Pairs left/right 16-bit samples from an I2S slave receiver into 32-bit
// frames {left, right} and queues them in a first-word-fall-through FIFO.
//
// Ports
//   i2s_clk_int    : I2S bit clock, all logic on its rising edge
//   rst            : asynchronous, active-high reset
//   enable_i       : block enable; low flushes the pairing FSM and the FIFO
//   data_left_i    : left sample, qualified by push_left_i
//   data_right_i   : right sample, qualified by push_right_i
//   push_left_i    : one-cycle strobe, data_left_i valid
//   push_right_i   : one-cycle strobe, data_right_i valid
//   out_ready_i    : downstream accept
//   err_clr_i      : clears the sticky error flags (a same-cycle set wins)
//   out_data_o     : head frame {left[15:0], right[15:0]}, 0 when empty
//   out_valid_o    : FIFO not empty
//   level_o        : FIFO occupancy, 0..DEPTH
//   overflow_o     : sticky, a completed frame was dropped on a full FIFO
//   ch_err_o       : sticky, left/right strobe ordering violation
//   fsm_state_o    : pairing FSM state (0 = WAIT_L, 1 = WAIT_R)
//
// Output handshake (valid/ready): a frame transfers on every rising edge
// where out_valid_o && out_ready_i are both high. out_valid_o and out_data_o
// come from registers only and never depend on out_ready_i; while
// out_valid_o is high and out_ready_i is low the head frame is held stable.
//
// DEPTH must be a power of two in 2..16 so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module i2s_rx_frame_packer #(
   parameter int DEPTH = 8
) (
   input  logic                     i2s_clk_int,
   input  logic                     rst,
   input  logic                     enable_i,
   input  logic [15:0]              data_left_i,
   input  logic [15:0]              data_right_i,
   input  logic                     push_left_i,
   input  logic                     push_right_i,
   input  logic                     out_ready_i,
   input  logic                     err_clr_i,
   output logic [31:0]              out_data_o,
   output logic                     out_valid_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     overflow_o,
   output logic                     ch_err_o,
   output logic                     fsm_state_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

   typedef enum logic {
      WAIT_L = 1'b0,
      WAIT_R = 1'b1
   } state_t;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_t        state_q;
   logic [15:0]   left_q;
   logic [31:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic          overflow_q, overflow_d;
   logic          ch_err_q, ch_err_d;

   // ------------------------------------------------------------------------
   // Strobe decode. Strobes are ignored entirely while disabled, and a
   // simultaneous left+right pair is treated as an error, not as either one.
   // ------------------------------------------------------------------------
   logic strobe_l;
   logic strobe_r;
   logic strobe_both;

   assign strobe_both = enable_i & push_left_i & push_right_i;
   assign strobe_l    = enable_i & push_left_i & ~push_right_i;
   assign strobe_r    = enable_i & push_right_i & ~push_left_i;

   logic wr_req;
   logic ch_err_evt;

   assign wr_req     = strobe_r & (state_q == WAIT_R);
   assign ch_err_evt = strobe_both
                     | (strobe_l & (state_q == WAIT_R))
                     | (strobe_r & (state_q == WAIT_L));

   // ------------------------------------------------------------------------
   // FIFO control. A pop in the same cycle frees the slot a full-FIFO write
   // needs, so that write is accepted and no overflow is flagged.
   // ------------------------------------------------------------------------
   logic        fifo_full;
   logic        fifo_empty;
   logic        pop;
   logic        wr_accept;
   logic        ovf_evt;
   logic [31:0] wr_frame;

   assign fifo_full  = (level_q == LVL_FULL);
   assign fifo_empty = (level_q == '0);
   assign pop        = ~fifo_empty & out_ready_i;
   assign wr_accept  = wr_req & (~fifo_full | pop);
   assign ovf_evt    = wr_req & fifo_full & ~pop;
   assign wr_frame   = {left_q, data_right_i};

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (!enable_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
         case ({wr_accept, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
         endcase
      end
   end

   // Sticky flags: a set event in the clearing cycle wins. Flushing via
   // enable_i does not touch them.
   always_comb begin
      overflow_d = ovf_evt    | (overflow_q & ~err_clr_i);
      ch_err_d   = ch_err_evt | (ch_err_q   & ~err_clr_i);
   end

   // ------------------------------------------------------------------------
   // Pairing FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge i2s_clk_int or posedge rst) begin
      if (rst) begin
         state_q <= WAIT_L;
         left_q  <= '0;
      end else if (!enable_i) begin
         state_q <= WAIT_L;
         left_q  <= '0;
      end else begin
         case (state_q)
            WAIT_L: begin
               if (strobe_l) begin
                  left_q  <= data_left_i;
                  state_q <= WAIT_R;
               end
            end
            WAIT_R: begin
               if (strobe_l) begin
                  // Repeated left: the newer sample replaces the held one.
                  left_q <= data_left_i;
               end else if (strobe_r) begin
                  state_q <= WAIT_L;
               end
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // FIFO pointers, level and flags
   // ------------------------------------------------------------------------
   always_ff @(posedge i2s_clk_int or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         ch_err_q   <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
         ch_err_q   <= ch_err_d;
      end
   end

   // Storage needs no reset: an entry is only visible once level covers it.
   always_ff @(posedge i2s_clk_int) begin
      if (wr_accept) begin
         mem_q[wr_ptr_q] <= wr_frame;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign out_valid_o = ~fifo_empty;
   assign out_data_o  = fifo_empty ? 32'h0 : mem_q[rd_ptr_q];
   assign level_o     = level_q;
   assign overflow_o  = overflow_q;
   assign ch_err_o    = ch_err_q;
   assign fsm_state_o = (state_q == WAIT_R);

endmodule
